// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: FSM state codes,
// opcode constants, datapath mux-select encodings and small decode helpers.
package riscv_ctrl_pkg;

    // ------------------------------------------------------------------
    // FSM state encoding (17 states, 5 bits)
    // ------------------------------------------------------------------
    typedef logic [4:0] state_t;

    localparam state_t S_FETCH    = 5'd0;
    localparam state_t S_DECODE   = 5'd1;
    localparam state_t S_MEMADR   = 5'd2;
    localparam state_t S_MEMREAD  = 5'd3;
    localparam state_t S_MEMWB    = 5'd4;
    localparam state_t S_MEMWRITE = 5'd5;
    localparam state_t S_EXECR    = 5'd6;
    localparam state_t S_EXECI    = 5'd7;
    localparam state_t S_ALUWB    = 5'd8;
    localparam state_t S_BRANCH   = 5'd9;
    localparam state_t S_JAL      = 5'd10;
    localparam state_t S_JALR     = 5'd11;
    localparam state_t S_LINK     = 5'd12;
    localparam state_t S_LUI      = 5'd13;
    localparam state_t S_AUIPC    = 5'd14;
    localparam state_t S_TRAP     = 5'd15;
    localparam state_t S_HALT     = 5'd16;

    // ------------------------------------------------------------------
    // Opcodes (instr[6:0])
    // ------------------------------------------------------------------
    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_RTYPE  = 7'b0110011;
    localparam opcode_t OP_ITYPE  = 7'b0010011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_SYSTEM = 7'b1110011;

    // ------------------------------------------------------------------
    // Datapath select encodings
    // ------------------------------------------------------------------
    typedef logic [1:0] result_src_t;
    localparam result_src_t RES_ALUOUT    = 2'b00;
    localparam result_src_t RES_DATA      = 2'b01;
    localparam result_src_t RES_ALURESULT = 2'b10;

    typedef logic [1:0] alu_src_a_t;
    localparam alu_src_a_t SRCA_PC    = 2'b00;
    localparam alu_src_a_t SRCA_OLDPC = 2'b01;
    localparam alu_src_a_t SRCA_RS1   = 2'b10;
    localparam alu_src_a_t SRCA_ZERO  = 2'b11;

    typedef logic [1:0] alu_src_b_t;
    localparam alu_src_b_t SRCB_RS2  = 2'b00;
    localparam alu_src_b_t SRCB_IMM  = 2'b01;
    localparam alu_src_b_t SRCB_FOUR = 2'b10;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALUOP_ADD    = 2'b00;
    localparam alu_op_t ALUOP_BRANCH = 2'b01;
    localparam alu_op_t ALUOP_FUNCT  = 2'b10;

    typedef logic [2:0] imm_src_t;
    localparam imm_src_t IMM_I = 3'b000;
    localparam imm_src_t IMM_S = 3'b001;
    localparam imm_src_t IMM_B = 3'b010;
    localparam imm_src_t IMM_J = 3'b011;
    localparam imm_src_t IMM_U = 3'b100;

    // Complete control word produced by the output decode each cycle
    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        reg_write;
        logic        ir_write;
        logic        adr_src;
        logic        pc_update;
        logic        branch;
        result_src_t result_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        imm_src_t    imm_src;
        logic        trap;
        logic        halted;
        logic        instr_retired;
    } ctrl_t;

    // True for every opcode the core executes; SYSTEM is deliberately absent
    function automatic logic is_known_op(input opcode_t op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // State following DECODE for a given opcode
    function automatic state_t decode_next(input opcode_t op, input logic trap_en);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return trap_en ? S_TRAP : S_FETCH;
        endcase
    endfunction

    // Immediate format selected while in DECODE
    function automatic imm_src_t decode_imm_src(input opcode_t op);
        case (op)
            OP_BRANCH:       return IMM_B;
            OP_JAL:          return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:         return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath/memory (slave).
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWrite;
    logic             RegWrite;
    logic             IRWrite;
    logic             AdrSrc;
    logic             PCUpdate;
    logic             Branch;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [2:0]       ImmSrc;
    logic             trap;
    logic             halted;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  op, mem_ready,
        output mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
               trap, halted, instr_retired, retired_cnt
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
               trap, halted, instr_retired, retired_cnt
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count one per retire pulse; synchronous clear
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the RV32I multi-cycle core: sequences fetch, decode,
// execute and writeback, stretches memory states on mem_ready, traps on
// illegal/SYSTEM opcodes and counts retired instructions.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit TRAP_EN     = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_ctrl;
    logic             w_ready;
    logic [CNT_W-1:0] w_count;

    // With wait states disabled the memory is assumed to finish every access at once
    assign w_ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;
            S_DECODE:   w_next = decode_next(bus.op, TRAP_EN);
            S_MEMADR:   w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_LINK;
            S_LINK:     w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_TRAP:     w_next = S_HALT;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // Output decode: Moore per state, with mem_ready gating the FETCH and MEMWRITE commits
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.ir_write   = w_ready;
                w_ctrl.pc_update  = w_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a     = SRCA_OLDPC;
                w_ctrl.alu_src_b     = SRCB_IMM;
                w_ctrl.imm_src       = decode_imm_src(bus.op);
                // Unknown opcodes retire here as a NOP when trapping is disabled
                w_ctrl.instr_retired = (TRAP_EN == 1'b0) && !is_known_op(bus.op);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = bus.op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.result_src    = RES_DATA;
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                // MemWrite is held through the wait; memory commits on the ready cycle
                w_ctrl.mem_req       = 1'b1;
                w_ctrl.adr_src       = 1'b1;
                w_ctrl.mem_write     = 1'b1;
                w_ctrl.imm_src       = IMM_S;
                w_ctrl.instr_retired = w_ready;
            end
            S_EXECR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.result_src    = RES_ALUOUT;
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = SRCA_RS1;
                w_ctrl.alu_src_b     = SRCB_RS2;
                w_ctrl.alu_op        = ALUOP_BRANCH;
                w_ctrl.branch        = 1'b1;
                w_ctrl.imm_src       = IMM_B;
                w_ctrl.instr_retired = 1'b1;
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
                w_ctrl.imm_src    = IMM_J;
            end
            S_JALR: begin
                // PC <= rs1 + imm straight from the ALU result
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.pc_update  = 1'b1;
            end
            S_LINK: begin
                // Link value OldPC + 4, written back in ALUWB
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_FOUR;
            end
            S_LUI: begin
                w_ctrl.alu_src_a = SRCA_ZERO;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = IMM_U;
            end
            S_AUIPC: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = IMM_U;
            end
            S_TRAP: begin
                w_ctrl.trap = 1'b1;
            end
            S_HALT: begin
                w_ctrl.halted = 1'b1;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
        // Reset aborts whatever is in flight: nothing is enabled and nothing retires
        if (reset) begin
            w_ctrl = '0;
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_ctrl.instr_retired),
        .count (w_count)
    );

    assign bus.mem_req       = w_ctrl.mem_req;
    assign bus.MemWrite      = w_ctrl.mem_write;
    assign bus.RegWrite      = w_ctrl.reg_write;
    assign bus.IRWrite       = w_ctrl.ir_write;
    assign bus.AdrSrc        = w_ctrl.adr_src;
    assign bus.PCUpdate      = w_ctrl.pc_update;
    assign bus.Branch        = w_ctrl.branch;
    assign bus.ResultSrc     = w_ctrl.result_src;
    assign bus.ALUSrcA       = w_ctrl.alu_src_a;
    assign bus.ALUSrcB       = w_ctrl.alu_src_b;
    assign bus.ALUOp         = w_ctrl.alu_op;
    assign bus.ImmSrc        = w_ctrl.imm_src;
    assign bus.trap          = w_ctrl.trap;
    assign bus.halted        = w_ctrl.halted;
    assign bus.instr_retired = w_ctrl.instr_retired;
    assign bus.retired_cnt   = reset ? '0 : w_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: a cycle-by-cycle vector table drives the default
// configuration; hand-written sequences exercise a second instance with
// wait states off, trapping off and a 4-bit retire counter.
module tb_multicycle_ctrl_fsm;

    // Expected control word, one field per output
    typedef struct packed {
        logic       mem_req, mem_write, reg_write, ir_write, adr_src, pc_update, branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       trap, halted, retired;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        ctl_t       exp;
        int         cnt;
    } vec_t;

    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_BAD  = 7'b0000000;

    // Expected outputs per state, taken from the state/output table
    localparam ctl_t Z          = '0;
    localparam ctl_t FETCH_WAIT = '{mem_req:1'b1, alu_src_b:2'b10, result_src:2'b10, default:0};
    localparam ctl_t FETCH_GO   = '{mem_req:1'b1, alu_src_b:2'b10, result_src:2'b10,
                                    ir_write:1'b1, pc_update:1'b1, default:0};
    localparam ctl_t DEC_I      = '{alu_src_a:2'b01, alu_src_b:2'b01, default:0};
    localparam ctl_t DEC_B      = '{alu_src_a:2'b01, alu_src_b:2'b01, imm_src:3'b010, default:0};
    localparam ctl_t DEC_J      = '{alu_src_a:2'b01, alu_src_b:2'b01, imm_src:3'b011, default:0};
    localparam ctl_t DEC_U      = '{alu_src_a:2'b01, alu_src_b:2'b01, imm_src:3'b100, default:0};
    localparam ctl_t DEC_NOP    = '{alu_src_a:2'b01, alu_src_b:2'b01, retired:1'b1, default:0};
    localparam ctl_t MEMADR_L   = '{alu_src_a:2'b10, alu_src_b:2'b01, default:0};
    localparam ctl_t MEMADR_S   = '{alu_src_a:2'b10, alu_src_b:2'b01, imm_src:3'b001, default:0};
    localparam ctl_t MEMREAD    = '{mem_req:1'b1, adr_src:1'b1, default:0};
    localparam ctl_t MEMWB      = '{result_src:2'b01, reg_write:1'b1, retired:1'b1, default:0};
    localparam ctl_t MEMWR_WAIT = '{mem_req:1'b1, adr_src:1'b1, mem_write:1'b1, imm_src:3'b001, default:0};
    localparam ctl_t MEMWR_GO   = '{mem_req:1'b1, adr_src:1'b1, mem_write:1'b1, imm_src:3'b001,
                                    retired:1'b1, default:0};
    localparam ctl_t EXECR      = '{alu_src_a:2'b10, alu_op:2'b10, default:0};
    localparam ctl_t EXECI      = '{alu_src_a:2'b10, alu_src_b:2'b01, alu_op:2'b10, default:0};
    localparam ctl_t ALUWB      = '{reg_write:1'b1, retired:1'b1, default:0};
    localparam ctl_t BRANCH     = '{alu_src_a:2'b10, alu_op:2'b01, branch:1'b1, imm_src:3'b010,
                                    retired:1'b1, default:0};
    localparam ctl_t JAL        = '{alu_src_a:2'b01, alu_src_b:2'b10, pc_update:1'b1, imm_src:3'b011, default:0};
    localparam ctl_t JALR       = '{alu_src_a:2'b10, alu_src_b:2'b01, result_src:2'b10, pc_update:1'b1, default:0};
    localparam ctl_t LINK       = '{alu_src_a:2'b01, alu_src_b:2'b10, default:0};
    localparam ctl_t LUI        = '{alu_src_a:2'b11, alu_src_b:2'b01, imm_src:3'b100, default:0};
    localparam ctl_t AUIPC      = '{alu_src_a:2'b01, alu_src_b:2'b01, imm_src:3'b100, default:0};
    localparam ctl_t TRAP       = '{trap:1'b1, default:0};
    localparam ctl_t HALT       = '{halted:1'b1, default:0};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t vecs[$];
    ctl_t ctl_a;
    ctl_t ctl_b;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(32)) bus_a ();
    multicycle_ctrl_fsm_if #(.CNT_W(4))  bus_b ();

    multicycle_ctrl_fsm #(
        .MEM_WAIT_EN (1'b1),
        .TRAP_EN     (1'b1),
        .CNT_W       (32)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    multicycle_ctrl_fsm #(
        .MEM_WAIT_EN (1'b0),
        .TRAP_EN     (1'b0),
        .CNT_W       (4)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    assign ctl_a = {bus_a.mem_req, bus_a.MemWrite, bus_a.RegWrite, bus_a.IRWrite, bus_a.AdrSrc,
                    bus_a.PCUpdate, bus_a.Branch, bus_a.ResultSrc, bus_a.ALUSrcA, bus_a.ALUSrcB,
                    bus_a.ALUOp, bus_a.ImmSrc, bus_a.trap, bus_a.halted, bus_a.instr_retired};
    assign ctl_b = {bus_b.mem_req, bus_b.MemWrite, bus_b.RegWrite, bus_b.IRWrite, bus_b.AdrSrc,
                    bus_b.PCUpdate, bus_b.Branch, bus_b.ResultSrc, bus_b.ALUSrcA, bus_b.ALUSrcB,
                    bus_b.ALUOp, bus_b.ImmSrc, bus_b.trap, bus_b.halted, bus_b.instr_retired};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [6:0] op, input logic mr,
                       input ctl_t exp, input int cnt);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.mr  = mr;
        v.exp = exp;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive instance B for one cycle; outputs are valid on return
    task automatic step_b(input logic rst, input logic [6:0] op, input logic mr);
        @(negedge clk);
        rst_b         = rst;
        bus_b.op      = op;
        bus_b.mem_ready = mr;
        #1;
    endtask

    initial begin
        int pulses;

        rst_a           = 1'b1;
        rst_b           = 1'b1;
        bus_a.op        = OP_R;
        bus_a.mem_ready = 1'b0;
        bus_b.op        = OP_R;
        bus_b.mem_ready = 1'b0;

        // ---------------- vector table for instance A ----------------
        add(1, OP_R, 0, Z, 0);
        // R-type, no waits
        add(0, OP_R, 1, FETCH_GO, 0); add(0, OP_R, 1, DEC_I, 0);
        add(0, OP_R, 0, EXECR, 0);    add(0, OP_R, 1, ALUWB, 0);
        // lw: 2 waits in FETCH, 3 in MEMREAD -> 10 cycles
        add(0, OP_L, 0, FETCH_WAIT, 1); add(0, OP_L, 0, FETCH_WAIT, 1);
        add(0, OP_L, 1, FETCH_GO, 1);   add(0, OP_L, 0, DEC_I, 1);
        add(0, OP_L, 0, MEMADR_L, 1);
        add(0, OP_L, 0, MEMREAD, 1); add(0, OP_L, 0, MEMREAD, 1); add(0, OP_L, 0, MEMREAD, 1);
        add(0, OP_L, 1, MEMREAD, 1); add(0, OP_L, 0, MEMWB, 1);
        // sw: 2 waits in MEMWRITE
        add(0, OP_S, 1, FETCH_GO, 2);   add(0, OP_S, 1, DEC_I, 2);
        add(0, OP_S, 1, MEMADR_S, 2);
        add(0, OP_S, 0, MEMWR_WAIT, 2); add(0, OP_S, 0, MEMWR_WAIT, 2);
        add(0, OP_S, 1, MEMWR_GO, 2);
        // jalr
        add(0, OP_JALR, 1, FETCH_GO, 3); add(0, OP_JALR, 1, DEC_I, 3);
        add(0, OP_JALR, 1, JALR, 3);     add(0, OP_JALR, 0, LINK, 3);
        add(0, OP_JALR, 1, ALUWB, 3);
        // branch
        add(0, OP_B, 1, FETCH_GO, 4); add(0, OP_B, 1, DEC_B, 4); add(0, OP_B, 1, BRANCH, 4);
        // jal
        add(0, OP_JAL, 1, FETCH_GO, 5); add(0, OP_JAL, 0, DEC_J, 5);
        add(0, OP_JAL, 1, JAL, 5);      add(0, OP_JAL, 1, ALUWB, 5);
        // lui
        add(0, OP_LUI, 1, FETCH_GO, 6); add(0, OP_LUI, 1, DEC_U, 6);
        add(0, OP_LUI, 1, LUI, 6);      add(0, OP_LUI, 1, ALUWB, 6);
        // auipc
        add(0, OP_AUI, 1, FETCH_GO, 7); add(0, OP_AUI, 1, DEC_U, 7);
        add(0, OP_AUI, 1, AUIPC, 7);    add(0, OP_AUI, 1, ALUWB, 7);
        // I-type ALU
        add(0, OP_I, 1, FETCH_GO, 8); add(0, OP_I, 1, DEC_I, 8);
        add(0, OP_I, 1, EXECI, 8);    add(0, OP_I, 1, ALUWB, 8);
        // illegal opcode: trap, then halt for 20 cycles regardless of inputs
        add(0, OP_BAD, 1, FETCH_GO, 9); add(0, OP_BAD, 1, DEC_I, 9);
        add(0, OP_BAD, 1, TRAP, 9);
        for (int i = 0; i < 20; i++) add(0, OP_R, logic'(i % 2), HALT, 9);
        // reset out of HALT
        add(1, OP_R, 1, Z, 0);
        add(0, OP_R, 1, FETCH_GO, 0); add(0, OP_R, 1, DEC_I, 0);
        add(0, OP_R, 1, EXECR, 0);    add(0, OP_R, 1, ALUWB, 0);
        // reset in the middle of a MEMREAD wait: no retire, back to FETCH
        add(0, OP_L, 1, FETCH_GO, 1); add(0, OP_L, 1, DEC_I, 1);
        add(0, OP_L, 1, MEMADR_L, 1); add(0, OP_L, 0, MEMREAD, 1);
        add(1, OP_L, 0, Z, 0);
        add(0, OP_L, 0, FETCH_WAIT, 0); add(0, OP_L, 1, FETCH_GO, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_a           = vecs[i].rst;
            bus_a.op        = vecs[i].op;
            bus_a.mem_ready = vecs[i].mr;
            #1;
            check($sformatf("a_vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].exp));
            check($sformatf("a_vec%0d_cnt", i), bus_a.retired_cnt, vecs[i].cnt);
        end

        // ---------------- hand sequences for instance B ----------------
        step_b(1, OP_R, 1);
        check("b_reset_outputs", 32'(ctl_b), 32'(Z));

        // 17 R-type instructions with mem_ready low (ignored): counter wraps to 1
        for (int k = 0; k < 17; k++) begin
            step_b(0, OP_R, 0);
            if (k == 0) check("b_fetch_no_wait", 32'(ctl_b), 32'(FETCH_GO));
            check($sformatf("b_cnt_before_instr%0d", k), 32'(bus_b.retired_cnt), k % 16);
            pulses = int'(bus_b.instr_retired);
            for (int c = 0; c < 3; c++) begin
                step_b(0, OP_R, 0);
                pulses += int'(bus_b.instr_retired);
            end
            check($sformatf("b_retire_pulses%0d", k), pulses, 1);
        end

        // illegal opcode with trapping disabled: 2-cycle NOP
        step_b(0, OP_BAD, 0);
        check("b_wrap_cnt", 32'(bus_b.retired_cnt), 1);
        step_b(0, OP_BAD, 0);
        check("b_nop_decode", 32'(ctl_b), 32'(DEC_NOP));
        step_b(0, OP_SYS, 0);
        check("b_nop_back_to_fetch", 32'(ctl_b), 32'(FETCH_GO));
        check("b_nop_cnt", 32'(bus_b.retired_cnt), 2);
        // SYSTEM likewise retires as NOP
        step_b(0, OP_SYS, 0);
        check("b_sys_decode", 32'(ctl_b), 32'(DEC_NOP));

        // lw with mem_ready low everywhere: no MEMREAD stall
        step_b(0, OP_L, 0);
        check("b_sys_cnt", 32'(bus_b.retired_cnt), 3);
        step_b(0, OP_L, 0);
        step_b(0, OP_L, 0);
        check("b_lw_memadr", 32'(ctl_b), 32'(MEMADR_L));
        step_b(0, OP_L, 0);
        check("b_lw_memread", 32'(ctl_b), 32'(MEMREAD));
        step_b(0, OP_L, 0);
        check("b_lw_memwb", 32'(ctl_b), 32'(MEMWB));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
